uart_word_tx: RTL and testbench

Serializes one 32-bit word into four back-to-back 8N1 UART frames on a single serial line. Bytes go least-significant first, and bits within each byte go LSB first. The block sits at the output of the FPU datapath and streams each `result` word back to the host. It mirrors the framing the host-side receiver uses to assemble 32-bit operands.

---
 rtl/uart_word_tx_if.sv | 16 +
 rtl/uart_word_tx.sv | 186 ++++++++++++++++++
 tb/tb_uart_word_tx.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_word_tx_if.sv
// ---------------------------------------------------------------------------
// uart_word_tx_if
// Word handshake between the FPU result stage (master) and the serializer
// (slave).
//   tx_valid : master -> slave, a word is offered on tx_data
//   tx_data  : master -> slave, 32-bit word, sampled only on acceptance
//   tx_ready : slave -> master, serializer can take a word this cycle
// ---------------------------------------------------------------------------
interface uart_word_tx_if;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic        tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_word_tx.sv
// ---------------------------------------------------------------------------
// uart_word_tx
// Serializes one 32-bit word as four back-to-back UART frames, byte 0 (LSB)
// first and bits LSB first within each byte. Frames are 8N1 by default.
//
// Optional feature: define UART_WORD_TX_PARITY_EN to insert an even-parity
// bit between the data bits and the stop bit (8E1, 11-bit frames).
//
// Ports:
//   clk       : clock, all state changes on the rising edge
//   reset     : asynchronous active-low reset
//   bus       : slave side of uart_word_tx_if (tx_valid/tx_data/tx_ready)
//   tx_out    : serial line, idle high, driven straight from a register
//   tx_led    : high while a word is being sent
//   byte_done : one-cycle pulse when each byte's stop bit ends
//   word_done : one-cycle pulse when the last byte's stop bit ends
//
// Parameters:
//   CLKS_PER_BIT : clock cycles per UART bit (>= 2)
//   NUM_BYTES    : bytes per word, fixed at 4 for the 32-bit word
// ---------------------------------------------------------------------------
module uart_word_tx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int NUM_BYTES    = 4
) (
  input  logic          clk,
  input  logic          reset,
  uart_word_tx_if.slave bus,
  output logic          tx_out,
  output logic          tx_led,
  output logic          byte_done,
  output logic          word_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W = $clog2(NUM_BYTES);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_WORD_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } state_t;

  state_t            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_q;
  logic [BYTE_W-1:0] byte_q;
  logic [31:0]       shift_q;
  logic              tx_out_q;
  logic              ready_q;
  logic              led_q;
  logic              byte_done_q;
  logic              word_done_q;
`ifdef UART_WORD_TX_PARITY_EN
  logic              parity_q;
`endif

  // Last cycle of the current bit cell.
  logic bit_end;
  assign bit_end = (baud_q == BAUD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      shift_q     <= '0;
      tx_out_q    <= 1'b1;
      ready_q     <= 1'b1;
      led_q       <= 1'b0;
      byte_done_q <= 1'b0;
      word_done_q <= 1'b0;
`ifdef UART_WORD_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      // Completion flags are single-cycle pulses.
      byte_done_q <= 1'b0;
      word_done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (bus.tx_valid && ready_q) begin
            shift_q  <= bus.tx_data;
            byte_q   <= '0;
            bit_q    <= '0;
            baud_q   <= '0;
            tx_out_q <= 1'b0;          // start bit begins on the acceptance edge
            ready_q  <= 1'b0;
            led_q    <= 1'b1;
            state_q  <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            baud_q   <= '0;
            bit_q    <= '0;
            tx_out_q <= shift_q[0];
`ifdef UART_WORD_TX_PARITY_EN
            parity_q <= ^shift_q[7:0];  // byte about to go out sits in the low bits
`endif
            state_q  <= S_DATA;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end

        S_DATA: begin
          if (bit_end) begin
            baud_q  <= '0;
            // Shifting on the last bit as well leaves the next byte in [7:0].
            shift_q <= shift_q >> 1;
            if (bit_q == 3'd7) begin
`ifdef UART_WORD_TX_PARITY_EN
              tx_out_q <= parity_q;
              state_q  <= S_PARITY;
`else
              tx_out_q <= 1'b1;
              state_q  <= S_STOP;
`endif
            end else begin
              bit_q    <= bit_q + 3'd1;
              tx_out_q <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end

`ifdef UART_WORD_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            baud_q   <= '0;
            tx_out_q <= 1'b1;
            state_q  <= S_STOP;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
`endif

        S_STOP: begin
          if (bit_end) begin
            baud_q      <= '0;
            byte_done_q <= 1'b1;
            if (byte_q == BYTE_LAST) begin
              word_done_q <= 1'b1;
              ready_q     <= 1'b1;
              led_q       <= 1'b0;
              state_q     <= S_IDLE;       // line stays high
            end else begin
              byte_q   <= byte_q + BYTE_W'(1);
              tx_out_q <= 1'b0;
              state_q  <= S_START;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end

        default: begin
          state_q  <= S_IDLE;
          tx_out_q <= 1'b1;
          ready_q  <= 1'b1;
          led_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_ready = ready_q;
  assign tx_out       = tx_out_q;
  assign tx_led       = led_q;
  assign byte_done    = byte_done_q;
  assign word_done    = word_done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_word_tx
// Self-checking bench for uart_word_tx with CLKS_PER_BIT = 4. Expected line
// levels come from frame arithmetic on the word (cell index, byte, position
// within the frame); pulses and handshake are checked against the nominal
// timeline relative to the acceptance edge. Compile with
// UART_WORD_TX_PARITY_EN defined to exercise the parity build.
// ---------------------------------------------------------------------------
module tb_uart_word_tx;

  localparam int C = 4;
`ifdef UART_WORD_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif
  localparam int L   = 4 * F * C;      // acceptance to word_done, in cycles
  localparam int CAP = 2 * L + 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic tx_out, tx_led, byte_done, word_done;

  uart_word_tx_if bus ();

  uart_word_tx #(.CLKS_PER_BIT(C), .NUM_BYTES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .tx_out   (tx_out),
    .tx_led   (tx_led),
    .byte_done(byte_done),
    .word_done(word_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-cycle capture after an acceptance edge; index t = state after edge E0+t.
  logic        line_a [CAP];
  logic        bd_a   [CAP];
  logic        wd_a   [CAP];
  logic        rdy_a  [CAP];
  logic        led_a  [CAP];
  // Inputs driven after sampling offset t (so they are seen by edge E0+t+1).
  logic        stim_v [CAP];
  logic [31:0] stim_d [CAP];

  // Expected line level t cycles after the acceptance edge of word w.
  function automatic logic exp_line(input logic [31:0] w, input int t);
    int idx, b, k;
    logic [7:0] by;
    idx = t / C;
    b   = idx / F;
    k   = idx % F;
    if (b >= 4) return 1'b1;
    by = w[8*b +: 8];
    if (k == 0) return 1'b0;
    if (k <= 8) return by[k-1];
    if (F == 11 && k == 9) return ^by;
    return 1'b1;
  endfunction

  task automatic fill_stim(input logic v);
    for (int t = 0; t < CAP; t++) begin
      stim_v[t] = v;
      stim_d[t] = $urandom;
    end
  endtask

  task automatic accept(input logic [31:0] w, input string name);
    bit got;
    got = 1'b0;
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = w;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (bus.tx_ready === 1'b1) got = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (!got) $display("FAIL %s_accept: tx_ready=%b, required 1 within 2000 cycles", name, bus.tx_ready);
    else n_pass++;
    @(posedge clk);
  endtask

  task automatic capture(input int n);
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      line_a[t] = tx_out;
      bd_a[t]   = byte_done;
      wd_a[t]   = word_done;
      rdy_a[t]  = bus.tx_ready;
      led_a[t]  = tx_led;
      bus.tx_valid = stim_v[t];
      bus.tx_data  = stim_d[t];
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] w, input int base);
    int bad, first_bad, wd_cnt, wd_first, rdy_first;
    logic [31:0] dec;
    logic expb;

    // Line waveform, cycle by cycle.
    bad = 0; first_bad = -1;
    for (int t = 0; t <= L; t++)
      if (line_a[base+t] !== exp_line(w, t)) begin
        bad++;
        if (first_bad < 0) first_bad = t;
      end
    n_checks++;
    if (bad != 0) $display("FAIL %s_line: %0d wrong cycles, first at +%0d, required 0 wrong", name, bad, first_bad);
    else n_pass++;

    // Receiver view: sample the middle of each data cell.
    dec = '0;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++)
        dec[8*b+i] = line_a[base + (b*F + 1 + i)*C + C/2];
    n_checks++;
    if (dec !== w) $display("FAIL %s_decode: got %h, required %h", name, dec, w);
    else n_pass++;

    // byte_done exactly at every frame boundary.
    bad = 0; first_bad = -1;
    for (int t = 0; t <= L; t++) begin
      expb = (t > 0) && (t % (F*C) == 0);
      if (bd_a[base+t] !== expb) begin
        bad++;
        if (first_bad < 0) first_bad = t;
      end
    end
    n_checks++;
    if (bad != 0) $display("FAIL %s_byte_done: %0d wrong cycles, first at +%0d, required pulses at multiples of %0d", name, bad, first_bad, F*C);
    else n_pass++;

    // word_done once, at +L.
    wd_cnt = 0; wd_first = -1;
    for (int t = 0; t <= L; t++)
      if (wd_a[base+t] === 1'b1) begin
        wd_cnt++;
        if (wd_first < 0) wd_first = t;
      end
    n_checks++;
    if (wd_cnt != 1 || wd_first != L) $display("FAIL %s_word_done: %0d pulses, first at +%0d, required 1 at +%0d", name, wd_cnt, wd_first, L);
    else n_pass++;

    // tx_ready low through the word, back at +L.
    rdy_first = -1;
    for (int t = 0; t <= L; t++)
      if (rdy_first < 0 && rdy_a[base+t] === 1'b1) rdy_first = t;
    n_checks++;
    if (rdy_first != L) $display("FAIL %s_ready: first high at +%0d, required +%0d", name, rdy_first, L);
    else n_pass++;

    // tx_led high exactly while the word is in flight.
    bad = 0; first_bad = -1;
    for (int t = 0; t <= L; t++)
      if (led_a[base+t] !== (t < L)) begin
        bad++;
        if (first_bad < 0) first_bad = t;
      end
    n_checks++;
    if (bad != 0) $display("FAIL %s_led: %0d wrong cycles, first at +%0d, required high for +0..+%0d", name, bad, first_bad, L-1);
    else n_pass++;
  endtask

  task automatic test_reset();
    int bad;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    reset = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || bus.tx_ready !== 1'b1 || tx_led !== 1'b0 ||
          byte_done !== 1'b0 || word_done !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL reset_hold: %0d bad cycles (out=%b rdy=%b led=%b), required 0", bad, tx_out, bus.tx_ready, tx_led);
    else n_pass++;
    reset = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || bus.tx_ready !== 1'b1 || tx_led !== 1'b0 ||
          byte_done !== 1'b0 || word_done !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL reset_idle: %0d bad cycles, required 0", bad);
    else n_pass++;
  endtask

  task automatic test_single_word();
    accept(32'h4260_0000, "single");
    fill_stim(1'b0);
    capture(L + 2);
    check_word("single", 32'h4260_0000, 0);
  endtask

  task automatic test_busy_ignore();
    accept(32'hA5A5_5A5A, "busy");
    fill_stim(1'b0);
    for (int t = 9; t < L; t++) begin
      stim_v[t] = 1'b1;
      stim_d[t] = 32'hFFFF_FFFF;
    end
    capture(L + 2);
    check_word("busy", 32'hA5A5_5A5A, 0);
    n_checks++;
    if (led_a[L+1] !== 1'b0 || rdy_a[L+1] !== 1'b1)
      $display("FAIL busy_no_queue: led=%b rdy=%b at +%0d, required led=0 rdy=1", led_a[L+1], rdy_a[L+1], L+1);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    accept(32'h0000_0001, "b2b");
    fill_stim(1'b0);
    for (int t = 0; t <= L; t++) begin
      stim_v[t] = 1'b1;
      stim_d[t] = 32'h8000_0000;
    end
    capture(CAP);
    check_word("b2b_w0", 32'h0000_0001, 0);
    check_word("b2b_w1", 32'h8000_0000, L + 1);
    n_checks++;
    if (line_a[L] !== 1'b1 || line_a[L+1] !== 1'b0 || rdy_a[L] !== 1'b1 || rdy_a[L+1] !== 1'b0)
      $display("FAIL b2b_gap: line=%b%b rdy=%b%b at +%0d/+%0d, required line=10 rdy=10",
               line_a[L], line_a[L+1], rdy_a[L], rdy_a[L+1], L, L+1);
    else n_pass++;
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] w2;
    accept(32'h1234_5678, "midrst");
    #1 bus.tx_valid = 1'b0;
    repeat (56) @(posedge clk);
    #1;
    n_checks++;
    if (tx_out !== exp_line(32'h1234_5678, 57 - 1 + 1))
      $display("FAIL midrst_pre: tx_out=%b, required %b", tx_out, exp_line(32'h1234_5678, 57));
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (tx_out !== 1'b1 || bus.tx_ready !== 1'b1 || tx_led !== 1'b0)
      $display("FAIL midrst_async: out=%b rdy=%b led=%b, required 1 1 0", tx_out, bus.tx_ready, tx_led);
    else n_pass++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    w2 = $urandom;
    accept(w2, "midrst_next");
    fill_stim(1'b0);
    capture(L + 2);
    check_word("midrst_next", w2, 0);
  endtask

  task automatic test_random_words();
    logic [31:0] w;
    for (int n = 0; n < 3; n++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      w = $urandom;
      accept(w, "rand");
      fill_stim(1'b0);
      capture(L + 2);
      check_word("rand", w, 0);
    end
  endtask

`ifdef UART_WORD_TX_PARITY_EN
  task automatic test_parity();
    logic [3:0] pb;
    accept(32'h0000_0307, "parity");
    fill_stim(1'b0);
    capture(L + 2);
    check_word("parity", 32'h0000_0307, 0);
    for (int b = 0; b < 4; b++) pb[b] = line_a[(b*F + 9)*C + C/2];
    n_checks++;
    if (pb !== 4'b0001) $display("FAIL parity_bits: bytes0..3 = %b%b%b%b, required 1000", pb[0], pb[1], pb[2], pb[3]);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_word();
    test_random_words();
`ifdef UART_WORD_TX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
